// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and defaults.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CLKS = 65536;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: one-hot select of the first valid
// requester at or after the pointer, wrapping around.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o
);

  logic [NUM_REQ-1:0] valid_rot;
  logic [NUM_REQ-1:0] pick_rot;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    valid_rot = NUM_REQ'({valid_i, valid_i} >> ptr_i);
    pick_rot  = valid_rot & (~valid_rot + NUM_REQ'(1));
    grant_o   = NUM_REQ'(({pick_rot, pick_rot} << ptr_i) >> NUM_REQ);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte-stream requesters, with a stall/frame timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   Req_Valid,
  input  logic [NUM_REQ-1:0]   Req_Last,
  input  logic [8*NUM_REQ-1:0] Req_Data,
  output logic [NUM_REQ-1:0]   Req_Ready,
  output logic [NUM_REQ-1:0]   Grant,
  output logic                 Tx_EN,
  output logic [7:0]           Tx_Data,
  input  logic                 Tx_Done,
  output logic                 Busy,
  output logic                 Timeout_Err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [PW-1:0]      own_q, own_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               last_q, last_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               tmo_err_q, tmo_err_d;
  logic [31:0]        tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0] pick;
  logic [PW-1:0]      pick_idx;
  logic [7:0]         req_byte [NUM_REQ];
  logic               tmo_hit;
  logic               gap_done;

  // Slice the packed data bus into one byte per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = Req_Data[8*gi +: 8];
  end

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (Req_Valid),
    .ptr_i   (ptr_q),
    .grant_o (pick)
  );

  // Encode the one-hot pick into the owner index kept while the grant is held.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  assign tmo_hit  = (tmo_cnt_q == 32'(TIMEOUT_CLKS - 1));
  assign gap_done = (gap_cnt_q == GW'(GAP_CLKS));

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ready_d   = '0;
    own_d     = own_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    tmo_err_d = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
    gap_cnt_d = gap_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (|Req_Valid) begin
          grant_d   = pick;
          own_d     = pick_idx;
          tmo_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (Req_Valid[own_q]) begin
          tx_data_d      = req_byte[own_q];
          last_d         = Req_Last[own_q];
          ready_d[own_q] = 1'b1;
          tx_en_d        = 1'b1;
          tmo_cnt_d      = '0;
          state_d        = SEND;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          grant_d   = '0;
          ptr_d     = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + PW'(1);
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      SEND: begin
        // A done pulse on the terminal-count cycle still counts as success.
        if (Tx_Done) begin
          tx_en_d   = 1'b0;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          tx_en_d   = 1'b0;
          grant_d   = '0;
          ptr_d     = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + PW'(1);
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      GAP: begin
        // The final gap cycle takes a byte that is already waiting, so the
        // next frame starts without an extra LOAD bubble.
        if (!gap_done) begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end else if (last_q) begin
          grant_d = '0;
          ptr_d   = (own_q == PW'(NUM_REQ - 1)) ? '0 : own_q + PW'(1);
          state_d = IDLE;
        end else if (Req_Valid[own_q]) begin
          tx_data_d      = req_byte[own_q];
          last_d         = Req_Last[own_q];
          ready_d[own_q] = 1'b1;
          tx_en_d        = 1'b1;
          tmo_cnt_d      = '0;
          state_d        = SEND;
        end else begin
          tmo_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      default: begin
        grant_d = '0;
        tx_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ready_q   <= '0;
      own_q     <= '0;
      ptr_q     <= '0;
      last_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      tmo_err_q <= tmo_err_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign Req_Ready   = ready_q;
  assign Grant       = grant_q;
  assign Tx_EN       = tx_en_q;
  assign Tx_Data     = tx_data_q;
  assign Busy        = busy_q;
  assign Timeout_Err = tmo_err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte-stream requesters. It accepts bytes per requester over a valid/ready handshake and keeps the grant for a whole packet, from first byte to `Req_Last`. It drives the transmitter's enable/data inputs and sequences one frame at a time off the transmitter's done pulse. A timeout recovers from a transmitter that never completes a frame.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_CLKS`, 0: extra idle clocks inserted after each byte's done pulse.
- `TIMEOUT_CLKS`, 65536: max clocks in SEND or owner-stall in LOAD before abort; ≥ 2.
- `Clk` in 1: system clock.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `Req_Valid` in NUM_REQ: per-requester byte available.
- `Req_Last` in NUM_REQ: qualifies byte as last of packet.
- `Req_Data` in 8*NUM_REQ: byte i at [8i+7:8i].
- `Req_Ready` out NUM_REQ: one-cycle ack; byte taken.
- `Grant` out NUM_REQ: one-hot current owner, 0 when none.
- `Tx_EN` out 1: to transmitter enable.
- `Tx_Data` out 8: to transmitter data, held for whole frame.
- `Tx_Done` in 1: transmitter frame-complete pulse.
- `Busy` out 1: state ≠ IDLE.
- `Timeout_Err` out 1: one-cycle abort pulse.

## Operation
- All outputs registered. Reset values: `Req_Ready`=0, `Grant`=0, `Tx_EN`=0, `Tx_Data`=8'h00, `Busy`=0, `Timeout_Err`=0, state IDLE, rr pointer so requester 0 has top priority, counters 0.
- IDLE: if any `Req_Valid`, pick first valid index at/after pointer (wrapping), set `Grant`, → LOAD.
- LOAD: if `Req_Valid[g]`: latch byte into `Tx_Data`, latch `Req_Last[g]`, pulse `Req_Ready[g]`, set `Tx_EN`, → SEND. Else count stall. At `TIMEOUT_CLKS` stall, pulse `Timeout_Err`, release, → IDLE.
- SEND: hold `Tx_EN`=1 and `Tx_Data` stable. On `Tx_Done`, clear `Tx_EN` and → GAP. At `TIMEOUT_CLKS` with no done, pulse `Timeout_Err`, clear `Tx_EN`, drop the rest of the packet, release, → IDLE.
- GAP: wait `GAP_CLKS` clocks; this state always takes at least 1 cycle. If last flag set: release grant, pointer = g+1 mod NUM_REQ, → IDLE. Else → LOAD with same grant.
- Release: `Grant`←0 and pointer advanced past g, on every exit to IDLE, including aborts.
- Requester contract: hold `Req_Valid`/`Req_Data`/`Req_Last` until `Req_Ready`; it may change them in the `Req_Ready` cycle.
- `Req_Valid` from non-owners is ignored while `Grant`≠0. `Tx_Done` outside SEND is ignored.

## Timing
- Valid seen in IDLE at edge n: `Grant` at n+1; `Req_Ready`, `Tx_EN`, `Tx_Data` at n+2 if valid was held.
- `Tx_Done` at edge m: `Tx_EN`=0 at m+1. Next byte of the same packet: `Tx_EN` at m+2+`GAP_CLKS` if valid.
- Last byte: `Grant`=0 at m+2+`GAP_CLKS`. The next arbitration win takes one more cycle.
- Timeout counter is 32 bit, cleared on entry to LOAD and SEND. It aborts when the count reaches `TIMEOUT_CLKS`-1.
- `Tx_Done` and the timeout terminal count in the same cycle: done wins, no error.
- Reset asserted mid-frame: all outputs return to reset values immediately (async), including `Tx_EN`. The in-flight byte is lost and no `Timeout_Err` is raised.

## Structure
- Package `uart_arb_pkg`: state encoding constants (IDLE, LOAD, SEND, GAP) and default `TIMEOUT_CLKS`.
- Sub-module `uart_rr_pick`: combinational one-hot round-robin select from the valid mask and pointer, parameterised by `NUM_REQ`. Everything else lives in the top.

## Test plan
- Single packet: req 2 sends 3 bytes 8'hA5, 8'h3C, 8'hFF (last on FF), bench done pulse 5 clocks after `Tx_EN`. Expect 3 `Req_Ready[2]` pulses, `Tx_Data` sequence A5/3C/FF, `Grant`=4'b0100 throughout, then 0.
- Round robin: reqs 0, 1, 3 valid with 1-byte packets. Expect grant order 0, 1, 3, 0 with no starvation.
- Packet lock: req 0 sends a 4-byte packet while req 1 is valid throughout. Expect req 1 granted only after req 0's last byte.
- SEND timeout: `TIMEOUT_CLKS`=16, never pulse `Tx_Done`. Expect `Timeout_Err` pulse, `Tx_EN` low, `Grant` 0, and the next requester served.
- Owner stall: req 1 drops `Req_Valid` mid-packet for 20 clocks with `TIMEOUT_CLKS`=16. Expect abort and release. Then `GAP_CLKS`=3: `Tx_Done`-to-next-`Tx_EN` spacing is 5 clocks.
- Reset: assert reset during SEND. Expect `Tx_EN`=0 and `Grant`=0 without a clock edge, and req 0 served first after release.
